alu_mc: RTL

Multi-cycle, parametrised successor to the single-cycle datapath ALU. It adds XOR, signed and unsigned set-less-than, iterative shifts and an optional iterative multiplier. Operations are accepted through a start/ready handshake, and results come back registered with a one-cycle valid pulse. It sits in the execute stage, and the core's control unit stalls while `ready` is low.

---
 rtl/alu_mc_pkg.sv | 27 ++
 rtl/alu_mc_comb.sv | 61 ++++++
 rtl/alu_mc.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcodes, FSM state encoding and small decode helpers shared
// by the multi-cycle ALU and its combinational sub-block.
package alu_mc_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_mc_comb.sv
// alu_mc_comb: purely combinational single-cycle operations (ADD..SLTU).
// Any other opcode yields zero. adder_n_subtractor is the shared
// add/subtract carry chain that also produces the compare flags.
module adder_n_subtractor #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  logic [N-1:0] bx;

  assign bx          = b ^ {N{sub}};
  assign {cout, sum} = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, sub};
  // Two's-complement overflow: operands agree in sign, sum disagrees.
  assign ovf         = (a[N-1] == bx[N-1]) && (sum[N-1] != a[N-1]);
endmodule

module alu_mc_comb
  import alu_mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] y
);
  logic [XLEN-1:0] sum;
  logic            cout;
  logic            ovf;
  logic            sub;

  assign sub = (op != ALU_ADD);

  adder_n_subtractor #(.N(XLEN)) u_addsub (
    .a    (a),
    .b    (b),
    .sub  (sub),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  // Select the single-cycle result; compares come from the a-b flags.
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD, ALU_SUB: y = sum;
      ALU_AND:          y = a & b;
      ALU_OR:           y = a | b;
      ALU_XOR:          y = a ^ b;
      ALU_SLT:          y = {{(XLEN-1){1'b0}}, sum[XLEN-1] ^ ovf};
      ALU_SLTU:         y = {{(XLEN-1){1'b0}}, ~cout};
      default:          y = '0;
    endcase
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with start/ready handshake and one-cycle valid
// pulse. Shifts iterate one bit per cycle. Define ALU_MC_MUL_EN to build
// the iterative shift-add multiplier (opcode 10); otherwise opcode 10 is
// treated as illegal and the FSM only has IDLE and SHIFT.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alucontrol,
  output logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  // Counter must hold XLEN itself for the multiplier, hence one extra bit.
  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] sh_q, sh_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] comb_y;
  logic [XLEN-1:0] sh_nxt;
  logic [SHW-1:0]  shamt;
`ifdef ALU_MC_MUL_EN
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] acc_nxt;
`endif

  function automatic logic [XLEN-1:0] shift_one(input logic [3:0] op,
                                                input logic [XLEN-1:0] x);
    logic signed [XLEN-1:0] sx;
    sx = x;
    case (op)
      ALU_SLL: return x << 1;
      ALU_SRA: return sx >>> 1;
      default: return x >> 1;
    endcase
  endfunction

  alu_mc_comb #(.XLEN(XLEN)) u_comb (
    .a  (a),
    .b  (b),
    .op (alucontrol),
    .y  (comb_y)
  );

  assign shamt  = b[SHW-1:0];
  assign sh_nxt = shift_one(op_q, sh_q);
`ifdef ALU_MC_MUL_EN
  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  // Next-state and datapath updates for accept, shift and multiply steps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sh_d     = sh_q;
    result_d = result_q;
    valid_d  = 1'b0;
`ifdef ALU_MC_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d = alucontrol;
          if (is_shift(alucontrol) && (shamt != '0)) begin
            sh_d    = a;
            cnt_d   = {1'b0, shamt};
            state_d = ST_SHIFT;
          end
`ifdef ALU_MC_MUL_EN
          else if (alucontrol == ALU_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CW'(XLEN);
            state_d  = ST_MUL;
          end
`endif
          else begin
            // Zero-distance shifts pass A through; illegal opcodes give 0.
            valid_d  = 1'b1;
            result_d = is_shift(alucontrol) ? a : comb_y;
          end
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_ONE) begin
          result_d = sh_nxt;
          valid_d  = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          sh_d  = sh_nxt;
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`ifdef ALU_MC_MUL_EN
      ST_MUL: begin
        if (cnt_q == CNT_ONE) begin
          result_d = acc_nxt;
          valid_d  = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          acc_d    = acc_nxt;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CNT_ONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and visible outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  // Working datapath registers; only meaningful while the FSM is busy.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    sh_q <= sh_d;
`ifdef ALU_MC_MUL_EN
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
`endif
  end

  assign ready  = (state_q == ST_IDLE);
  assign valid  = valid_q;
  assign result = result_q;
  assign zero   = ~|result_q;

endmodule
